// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg
//   Shared definitions for the instruction encoder/streamer:
//   - op_e    : symbolic request opcode carried on req_op (5 bits)
//   - OPC_* / FUNCT_* : MIPS primary opcodes and SPECIAL funct codes,
//                       same values the stage decoder recognises
//   - state_e : encoder FSM state
//   - is_ctl_op : ops that own a branch delay slot
package instr_encoder_pkg;

  typedef enum logic [4:0] {
    OP_ADDU    = 5'd0,
    OP_SUBU    = 5'd1,
    OP_AND     = 5'd2,
    OP_OR      = 5'd3,
    OP_XOR     = 5'd4,
    OP_NOR     = 5'd5,
    OP_SLL     = 5'd6,
    OP_SRL     = 5'd7,
    OP_JR      = 5'd8,
    OP_SYSCALL = 5'd9,
    OP_ADDIU   = 5'd10,
    OP_ORI     = 5'd11,
    OP_LW      = 5'd12,
    OP_SW      = 5'd13,
    OP_BEQ     = 5'd14,
    OP_LUI     = 5'd15,
    OP_JAL     = 5'd16,
    OP_J       = 5'd17,
    OP_LI      = 5'd18
  } op_e;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  // SPECIAL funct codes (instr[5:0])
  localparam logic [5:0] FUNCT_SLL     = 6'h00;
  localparam logic [5:0] FUNCT_SRL     = 6'h02;
  localparam logic [5:0] FUNCT_JR      = 6'h08;
  localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;
  localparam logic [5:0] FUNCT_ADDU    = 6'h21;
  localparam logic [5:0] FUNCT_SUBU    = 6'h23;
  localparam logic [5:0] FUNCT_AND     = 6'h24;
  localparam logic [5:0] FUNCT_OR      = 6'h25;
  localparam logic [5:0] FUNCT_XOR     = 6'h26;
  localparam logic [5:0] FUNCT_NOR     = 6'h27;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,  // no word held
    ST_EMIT     = 2'd1,  // first/only word of a request held
    ST_EMIT_LO  = 2'd2,  // ori half of a two-word li held
    ST_EMIT_NOP = 2'd3   // delay-slot padding word held
  } state_e;

  // Control-transfer ops: the word after them executes in the delay slot.
  function automatic logic is_ctl_op(input logic [4:0] op);
    return (op == OP_BEQ) || (op == OP_J) || (op == OP_JAL) || (op == OP_JR);
  endfunction

endpackage

// File: rtl/instr_word_pack.sv
// instr_word_pack
//   Purely combinational packer: turns one symbolic op plus its fields into
//   a 32-bit MIPS word. Fields an encoding does not use are forced to zero.
//   OP_LI is not handled here; the top splits it into lui/ori first.
// Ports:
//   op     in  5   op_e value
//   rs     in  5   source register
//   rt     in  5   source/target register
//   rd     in  5   destination register
//   shamt  in  5   shift amount
//   imm    in  26  immediate (I-type uses [15:0], J-type uses [25:0])
//   word   out 32  packed instruction
//   known  out 1   op is one this packer can encode
module instr_word_pack
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        known
);

  always_comb begin
    word  = '0;
    known = 1'b1;
    case (op)
      OP_ADDU:    word = {OPC_SPECIAL, rs, rt, rd, 5'd0, FUNCT_ADDU};
      OP_SUBU:    word = {OPC_SPECIAL, rs, rt, rd, 5'd0, FUNCT_SUBU};
      OP_AND:     word = {OPC_SPECIAL, rs, rt, rd, 5'd0, FUNCT_AND};
      OP_OR:      word = {OPC_SPECIAL, rs, rt, rd, 5'd0, FUNCT_OR};
      OP_XOR:     word = {OPC_SPECIAL, rs, rt, rd, 5'd0, FUNCT_XOR};
      OP_NOR:     word = {OPC_SPECIAL, rs, rt, rd, 5'd0, FUNCT_NOR};
      OP_SLL:     word = {OPC_SPECIAL, 5'd0, rt, rd, shamt, FUNCT_SLL};
      OP_SRL:     word = {OPC_SPECIAL, 5'd0, rt, rd, shamt, FUNCT_SRL};
      OP_JR:      word = {OPC_SPECIAL, rs, 15'd0, FUNCT_JR};
      OP_SYSCALL: word = {26'd0, FUNCT_SYSCALL};
      OP_ADDIU:   word = {OPC_ADDIU, rs, rt, imm[15:0]};
      OP_ORI:     word = {OPC_ORI, rs, rt, imm[15:0]};
      OP_LW:      word = {OPC_LW, rs, rt, imm[15:0]};
      OP_SW:      word = {OPC_SW, rs, rt, imm[15:0]};
      OP_BEQ:     word = {OPC_BEQ, rs, rt, imm[15:0]};
      OP_LUI:     word = {OPC_LUI, 5'd0, rt, imm[15:0]};
      OP_J:       word = {OPC_J, imm};
      OP_JAL:     word = {OPC_JAL, imm};
      default:    known = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
//   Writer-side instruction streamer for the boot/test loader. Accepts one
//   symbolic request per handshake and emits MIPS machine words, each paired
//   with its IMEM byte address (BASE_ADDR, then +ADDR_STEP per word, wrapping).
//   li is expanded into lui/ori (one word when a half is zero). Unknown ops are
//   swallowed and raise the sticky err flag.
//
//   Optional build macro DELAY_SLOT_NOP_EN: after every beq/j/jal/jr word a
//   32'h0 NOP is emitted at the next address before the next request is taken.
//
//   Handshakes (both ports): a transfer happens on the posedge where
//   valid && ready are both 1. The producer holds valid and payload stable
//   until that edge; ready may depend combinationally on the consumer's ready
//   (req_ready uses out_ready so throughput stays at one word per cycle).
//
//   The FSM state lives in register `state` (state_e) for probing.
//
// Ports:
//   clk        in  1   clock
//   reset      in  1   synchronous, active-low reset
//   req_valid  in  1   request present
//   req_ready  out 1   request accepted this cycle when req_valid is also 1
//   req_op     in  5   op_e value
//   req_rs/rt/rd/shamt in 5  register / shift fields
//   req_imm    in  32  immediate (16b I-type, 26b J-type, 32b li)
//   out_valid  out 1   out_word/out_addr hold a word
//   out_ready  in  1   consumer takes the word
//   out_word   out 32  encoded instruction
//   out_addr   out 32  IMEM byte address of out_word
//   err        out 1   sticky unknown-op flag
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_shamt,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        err
);

  state_e      state, state_d;
  logic [31:0] word_q, lo_word_q, addr_q;
  logic        err_q, has_lo_q, nop_q;

  logic        hs, accept, last_word;
  logic        is_li, li_two, nop_d, req_known;
  logic [15:0] li_hi, li_lo;

  logic [4:0]  op_a, rs_a;
  logic [25:0] imm_a;
  logic [31:0] word_a, word_b;
  logic        known_a, known_b;

  // ---------------------------------------------------------------------
  // Request decode: li is rewritten into its first word on packer A, while
  // packer B always builds the trailing "ori rt,rt,lo" in case it is needed.
  // ---------------------------------------------------------------------
  assign is_li  = (req_op == OP_LI);
  assign li_hi  = req_imm[31:16];
  assign li_lo  = req_imm[15:0];
  assign li_two = is_li && (li_hi != 16'd0) && (li_lo != 16'd0);

  always_comb begin
    op_a  = req_op;
    rs_a  = req_rs;
    imm_a = req_imm[25:0];
    if (is_li) begin
      rs_a = 5'd0;
      if (li_hi == 16'd0) begin
        op_a  = OP_ORI;
        imm_a = {10'd0, li_lo};
      end else begin
        op_a  = OP_LUI;
        imm_a = {10'd0, li_hi};
      end
    end
  end

  instr_word_pack u_pack_a (
    .op    (op_a),
    .rs    (rs_a),
    .rt    (req_rt),
    .rd    (req_rd),
    .shamt (req_shamt),
    .imm   (imm_a),
    .word  (word_a),
    .known (known_a)
  );

  instr_word_pack u_pack_b (
    .op    (OP_ORI),
    .rs    (req_rt),
    .rt    (req_rt),
    .rd    (req_rd),
    .shamt (req_shamt),
    .imm   ({10'd0, li_lo}),
    .word  (word_b),
    .known (known_b)
  );

  // li is known whenever its ori half can be packed (always, for ORI).
  assign req_known = is_li ? known_b : known_a;

`ifdef DELAY_SLOT_NOP_EN
  assign nop_d = is_ctl_op(req_op);
`else
  assign nop_d = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_d;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (accept && req_known) state_d = ST_EMIT;
      end
      ST_EMIT, ST_EMIT_LO: begin
        if (hs) begin
          if (state == ST_EMIT && has_lo_q) state_d = ST_EMIT_LO;
          else if (nop_q)                   state_d = ST_EMIT_NOP;
          else if (accept && req_known)     state_d = ST_EMIT;
          else                              state_d = ST_IDLE;
        end
      end
      ST_EMIT_NOP: begin
        if (hs) state_d = (accept && req_known) ? ST_EMIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. The held word is the last of its request when no li
  // second half and no padding word remain behind it.
  // ---------------------------------------------------------------------
  always_comb begin
    out_valid = (state != ST_IDLE);
    hs        = out_valid && out_ready;
    case (state)
      ST_EMIT:     last_word = !has_lo_q && !nop_q;
      ST_EMIT_LO:  last_word = !nop_q;
      ST_EMIT_NOP: last_word = 1'b1;
      default:     last_word = 1'b0;
    endcase
    req_ready = (state == ST_IDLE) || (last_word && hs);
    accept    = req_valid && req_ready;
  end

  assign out_word = word_q;
  assign out_addr = addr_q;
  assign err      = err_q;

  // ---------------------------------------------------------------------
  // Datapath: held word, pending li half, padding flag, address, err.
  // A new request can only be accepted when nothing is pending, so loading
  // a request never races with advancing an expansion.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_q    <= '0;
      lo_word_q <= '0;
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      has_lo_q  <= 1'b0;
      nop_q     <= 1'b0;
    end else begin
      if (hs) addr_q <= addr_q + ADDR_STEP;
      if (accept && !req_known) err_q <= 1'b1;

      if (accept && req_known) begin
        word_q    <= word_a;
        lo_word_q <= word_b;
        has_lo_q  <= li_two;
        nop_q     <= nop_d;
      end else if (hs && state == ST_EMIT && has_lo_q) begin
        word_q   <= lo_word_q;
        has_lo_q <= 1'b0;
      end else if (hs && nop_q) begin
        word_q <= 32'h0000_0000;
        nop_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
//   Directed checks of the documented encodings, li expansion, back-to-back
//   throughput, backpressure, unknown ops and reset, followed by a random
//   request stream scored against a queue-based reference model.
//   Honours DELAY_SLOT_NOP_EN the same way the design does.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_3000;
`ifdef DELAY_SLOT_NOP_EN
  localparam bit NOP_EN = 1'b1;
`else
  localparam bit NOP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [31:0] imm;
  } req_t;

  logic        clk, reset;
  logic        req_valid, req_ready;
  logic [4:0]  req_op, req_rs, req_rt, req_rd, req_shamt;
  logic [31:0] req_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_word, out_addr;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  bit          last_q[$];
  req_t        req_q[$];
  logic [31:0] exp_addr;
  logic        exp_err_m;

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs    (req_rs),
    .req_rt    (req_rt),
    .req_rd    (req_rd),
    .req_shamt (req_shamt),
    .req_imm   (req_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_addr  (out_addr),
    .err       (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- checks ----------------
  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  function automatic req_t mk(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] imm);
    req_t r;
    r.op = op; r.rs = rs; r.rt = rt; r.rd = rd; r.sh = sh; r.imm = imm;
    return r;
  endfunction

  task automatic apply(input req_t r);
    req_op    = r.op;
    req_rs    = r.rs;
    req_rt    = r.rt;
    req_rd    = r.rd;
    req_shamt = r.sh;
    req_imm   = r.imm;
  endtask

  function automatic req_t rand_req();
    req_t r;
    logic [31:0] v;
    r.op  = 5'($urandom_range(0, 20));
    r.rs  = 5'($urandom);
    r.rt  = 5'($urandom);
    r.rd  = 5'($urandom);
    r.sh  = 5'($urandom);
    v     = $urandom;
    case ($urandom_range(0, 3))
      0:       r.imm = v & 32'h0000_FFFF;
      1:       r.imm = v & 32'hFFFF_0000;
      default: r.imm = v;
    endcase
    return r;
  endfunction

  // ---------------- reference model ----------------
  // Words a request should produce, built from the MIPS field layout with
  // shifts; the final word of each request is flagged as "last".
  function automatic void push_model(input req_t r);
    logic [31:0] w[$];
    logic [31:0] rs = 32'(r.rs);
    logic [31:0] rt = 32'(r.rt);
    logic [31:0] rd = 32'(r.rd);
    logic [31:0] sh = 32'(r.sh);
    logic [31:0] hi = r.imm >> 16;
    logic [31:0] lo = r.imm & 32'h0000_FFFF;
    logic [31:0] tgt = r.imm & 32'h03FF_FFFF;
    bit ctl = 1'b0;
    case (r.op)
      OP_ADDU:    w.push_back((rs << 21) | (rt << 16) | (rd << 11) | 32'h21);
      OP_SUBU:    w.push_back((rs << 21) | (rt << 16) | (rd << 11) | 32'h23);
      OP_AND:     w.push_back((rs << 21) | (rt << 16) | (rd << 11) | 32'h24);
      OP_OR:      w.push_back((rs << 21) | (rt << 16) | (rd << 11) | 32'h25);
      OP_XOR:     w.push_back((rs << 21) | (rt << 16) | (rd << 11) | 32'h26);
      OP_NOR:     w.push_back((rs << 21) | (rt << 16) | (rd << 11) | 32'h27);
      OP_SLL:     w.push_back((rt << 16) | (rd << 11) | (sh << 6) | 32'h00);
      OP_SRL:     w.push_back((rt << 16) | (rd << 11) | (sh << 6) | 32'h02);
      OP_JR:      begin w.push_back((rs << 21) | 32'h08); ctl = 1'b1; end
      OP_SYSCALL: w.push_back(32'h0000_000C);
      OP_ADDIU:   w.push_back((32'h09 << 26) | (rs << 21) | (rt << 16) | lo);
      OP_ORI:     w.push_back((32'h0D << 26) | (rs << 21) | (rt << 16) | lo);
      OP_LW:      w.push_back((32'h23 << 26) | (rs << 21) | (rt << 16) | lo);
      OP_SW:      w.push_back((32'h2B << 26) | (rs << 21) | (rt << 16) | lo);
      OP_BEQ:     begin w.push_back((32'h04 << 26) | (rs << 21) | (rt << 16) | lo); ctl = 1'b1; end
      OP_LUI:     w.push_back((32'h0F << 26) | (rt << 16) | lo);
      OP_J:       begin w.push_back((32'h02 << 26) | tgt); ctl = 1'b1; end
      OP_JAL:     begin w.push_back((32'h03 << 26) | tgt); ctl = 1'b1; end
      OP_LI: begin
        if (hi == 0) w.push_back((32'h0D << 26) | (rt << 16) | lo);
        else begin
          w.push_back((32'h0F << 26) | (rt << 16) | hi);
          if (lo != 0) w.push_back((32'h0D << 26) | (rt << 21) | (rt << 16) | lo);
        end
      end
      default: exp_err_m = 1'b1;
    endcase
    if (ctl && NOP_EN) w.push_back(32'h0000_0000);
    foreach (w[i]) begin
      exp_q.push_back(w[i]);
      last_q.push_back(i == w.size() - 1);
    end
  endfunction

  // ---------------- scoreboard-driven random stream ----------------
  task automatic run_stream(input int ready_pct);
    int          budget = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] pw = '0, pa = '0;
    while ((req_q.size() > 0 || exp_q.size() > 0) && budget < 3000) begin
      budget++;
      if (req_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        req_valid = 1'b1;
        apply(req_q[0]);
      end else begin
        req_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      check1("s_valid", out_valid, exp_q.size() > 0);
      check1("s_req_ready", req_ready, (exp_q.size() == 0) || (out_ready && last_q[0]));
      if (hold_prev) begin
        check32("s_hold_word", out_word, pw);
        check32("s_hold_addr", out_addr, pa);
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        check32("s_word", out_word, exp_q.pop_front());
        check32("s_addr", out_addr, exp_addr);
        void'(last_q.pop_front());
        exp_addr = exp_addr + 32'd4;
      end
      hold_prev = out_valid && !out_ready;
      pw = out_word;
      pa = out_addr;
      if (req_valid && req_ready) push_model(req_q.pop_front());
      tick();
    end
    req_valid = 1'b0;
    check32("s_drain_words", 32'(exp_q.size()), 32'd0);
    check32("s_drain_reqs", 32'(req_q.size()), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    req_valid = 1'b0;
    out_ready = 1'b0;
    apply(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0));
    do_reset();

    // Reset state
    #1;
    check1 ("rst_valid", out_valid, 1'b0);
    check32("rst_word",  out_word,  32'h0);
    check32("rst_addr",  out_addr,  BASE);
    check1 ("rst_err",   err,       1'b0);
    check1 ("rst_ready", req_ready, 1'b1);

    // addu rd=3, rs=1, rt=2: word one cycle after accept
    apply(mk(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0));
    req_valid = 1'b1; out_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    #1;
    check1 ("addu_valid", out_valid, 1'b1);
    check32("addu_word",  out_word,  32'h0022_1821);
    check32("addu_addr",  out_addr,  32'h0000_3000);
    tick();
    check1 ("addu_idle",  out_valid, 1'b0);
    check32("addu_next",  out_addr,  32'h0000_3004);

    // sw then ori back-to-back, no bubble
    do_reset();
    apply(mk(OP_SW, 5'd29, 5'd2, 5'd0, 5'd0, 32'd8));
    req_valid = 1'b1; out_ready = 1'b1;
    tick();
    apply(mk(OP_ORI, 5'd0, 5'd1, 5'd0, 5'd0, 32'h1234));
    #1;
    check32("sw_word",  out_word,  32'hAFA2_0008);
    check32("sw_addr",  out_addr,  32'h0000_3000);
    check1 ("sw_b2b_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    #1;
    check1 ("ori_valid", out_valid, 1'b1);
    check32("ori_word",  out_word,  32'h3401_1234);
    check32("ori_addr",  out_addr,  32'h0000_3004);
    tick();
    check1 ("ori_idle",  out_valid, 1'b0);

    // li expansions: two-word, ori-only, lui-only (back-to-back)
    do_reset();
    apply(mk(OP_LI, 5'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678));
    req_valid = 1'b1; out_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    #1;
    check32("li2_hi_word", out_word,  32'h3C05_1234);
    check32("li2_hi_addr", out_addr,  32'h0000_3000);
    check1 ("li2_mid_ready", req_ready, 1'b0);
    tick();
    check32("li2_lo_word", out_word,  32'h34A5_5678);
    check32("li2_lo_addr", out_addr,  32'h0000_3004);
    apply(mk(OP_LI, 5'd0, 5'd5, 5'd0, 5'd0, 32'h0000_ABCD));
    req_valid = 1'b1;
    #1;
    check1 ("li2_end_ready", req_ready, 1'b1);
    tick();
    apply(mk(OP_LI, 5'd0, 5'd5, 5'd0, 5'd0, 32'hABCD_0000));
    #1;
    check32("li_lo_only", out_word, 32'h3405_ABCD);
    check32("li_lo_addr", out_addr, 32'h0000_3008);
    check1 ("li_lo_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    #1;
    check32("li_hi_only", out_word, 32'h3C05_ABCD);
    check32("li_hi_addr", out_addr, 32'h0000_300C);
    tick();
    check1 ("li_idle", out_valid, 1'b0);

    // Backpressure on jal
    apply(mk(OP_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0C00));
    req_valid = 1'b1; out_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check1 ("bp_valid", out_valid, 1'b1);
      check32("bp_word",  out_word,  32'h0C00_0C00);
      check32("bp_addr",  out_addr,  32'h0000_3010);
      check1 ("bp_ready", req_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
`ifdef DELAY_SLOT_NOP_EN
    check1 ("jal_nop_valid", out_valid, 1'b1);
    check32("jal_nop_word",  out_word,  32'h0);
    check32("jal_nop_addr",  out_addr,  32'h0000_3014);
    tick();
`endif
    check1("jal_idle", out_valid, 1'b0);

    // Unknown op: accepted, nothing emitted, err sticky
    apply(mk(5'd31, 5'd1, 5'd2, 5'd3, 5'd4, 32'hFFFF_FFFF));
    req_valid = 1'b1;
    #1;
    check1("unk_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    #1;
    check1("unk_valid", out_valid, 1'b0);
    check1("unk_err",   err,       1'b1);

    // Reset in the middle of a li expansion
    apply(mk(OP_LI, 5'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678));
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check1 ("mid_li_valid", out_valid, 1'b1);
    check32("mid_li_word",  out_word,  32'h34A5_5678);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check1 ("mid_rst_valid", out_valid, 1'b0);
    check32("mid_rst_addr",  out_addr,  BASE);
    check1 ("mid_rst_err",   err,       1'b0);

    // beq with optional delay-slot padding
    apply(mk(OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 32'd3));
    req_valid = 1'b1; out_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    #1;
    check32("beq_word", out_word, 32'h1022_0003);
    check32("beq_addr", out_addr, 32'h0000_3000);
`ifdef DELAY_SLOT_NOP_EN
    check1 ("beq_ready", req_ready, 1'b0);
    tick();
    check1 ("beq_nop_valid", out_valid, 1'b1);
    check32("beq_nop_word",  out_word,  32'h0);
    check32("beq_nop_addr",  out_addr,  32'h0000_3004);
    tick();
    check1 ("beq_idle", out_valid, 1'b0);
`else
    check1 ("beq_ready", req_ready, 1'b1);
    tick();
    check1 ("beq_idle", out_valid, 1'b0);
    check32("beq_next", out_addr, 32'h0000_3004);
`endif

    // Random stream against the reference model
    do_reset();
    exp_addr  = BASE;
    exp_err_m = 1'b0;
    for (int i = 0; i < 60; i++) req_q.push_back(rand_req());
    run_stream(70);
    for (int i = 0; i < 40; i++) req_q.push_back(rand_req());
    run_stream(30);
    #1;
    check1("rand_err", err, exp_err_m);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
